counter_event_capture: RTL and testbench
========================================

// Module: counter_event_capture
// PURPOSE
//   Downstream stage of the 4-bit up/down counter. Samples the counter's result
//   every cycle its detect is high, stamps each sample with a free-running cycle
//   stamp, and buffers the events in a small FIFO. A consumer drains the FIFO
//   over a valid/ready handshake. Overflow is counted and flagged, never silently lost.
// PARAMETERS
//   SIZE     4   width of counter result (matches counter SIZE)
//   DEPTH    4   FIFO entries; power of two, >= 2
//   STAMP_W  8   width of cycle stamp
//   DROP_W   4   width of dropped-event counter
// PORTS
//   clk         in   1        clock; all logic on posedge
//   reset       in   1        synchronous, active-high reset
//   detect      in   1        counter detect; 1 = capture result this cycle
//   result      in   SIZE     counter result
//   out_ready   in   1        consumer accepts head entry this cycle
//   clr_ovf     in   1        clears ovf_flag and drop_cnt
//   out_valid   out  1        head entry valid
//   out_result  out  SIZE     head entry result
//   out_stamp   out  STAMP_W  head entry stamp
//   level       out  $clog2(DEPTH)+1  entries held
//   ovf_flag    out  1        sticky: >=1 event dropped since last clear
//   drop_cnt    out  DROP_W   events dropped, saturating
// BEHAVIOUR
//   - Reset (sync, high): stamp=0, pointers=0, level=0, out_valid=0,
//     out_result=0, out_stamp=0, ovf_flag=0, drop_cnt=0. Reset wins over all
//     inputs; reset mid-operation discards all buffered events.
//   - Stamp: increments by 1 every non-reset cycle, wraps 2^STAMP_W-1 -> 0.
//     Captured event carries stamp value of the cycle detect was sampled.
//   - push = detect; pop = out_valid & out_ready.
//   - Latency: event pushed in cycle N is visible on out_* in cycle N+1 at the
//     earliest (no combinational fall-through).
//   - out_* are registered/driven from head entry; out_result/out_stamp hold
//     value while out_valid=1 and out_ready=0; values undefined-but-stable
//     (hold last) when out_valid=0.
//   - Empty: pop ignored (out_valid=0). Push on empty -> level=1 next cycle.
//   - Full (level==DEPTH): push without pop -> event dropped, ovf_flag<=1,
//     drop_cnt<=drop_cnt+1 saturating at 2^DROP_W-1; FIFO unchanged.
//   - Full with push AND pop same cycle: both accepted, level stays DEPTH,
//     no drop.
//   - Push and pop same cycle, non-empty non-full: level unchanged.
//   - Pointers wrap modulo DEPTH; level never exceeds DEPTH.
//   - clr_ovf: ovf_flag<=0, drop_cnt<=0; if a drop occurs same cycle, clear
//     wins then flag sets: ovf_flag=1, drop_cnt=1.
//   - No FSM beyond pointer/level state; all outputs change only on posedge clk.
// STRUCTURE
//   - counter_pkg: typedef struct packed {logic [SIZE-1:0] result;
//     logic [STAMP_W-1:0] stamp;} cnt_event_t; shared SIZE default.
//   - Sub-module event_fifo: generic sync FIFO (DEPTH, width of cnt_event_t),
//     push/pop/full/empty/level. Top holds stamp, drop logic, handshake map.
// TESTING
//   1 reset then idle 10 cycles -> out_valid=0, level=0, stamp=10, ovf_flag=0.
//   2 detect=1 for one cycle at stamp=5 with result=4'hA, out_ready=0 ->
//     next cycle out_valid=1, out_result=A, out_stamp=5; held until out_ready=1.
//   3 detect=1 for 6 cycles, out_ready=0, DEPTH=4 -> level=4, drop_cnt=2,
//     ovf_flag=1; drain yields first 4 results in order.
//   4 FIFO full, detect=1 and out_ready=1 same cycle -> level stays 4,
//     drop_cnt unchanged, new entry appears after 3 further pops.
//   5 20 drops with DROP_W=4 -> drop_cnt=15; clr_ovf=1 -> 0 and flag 0.
//   6 reset asserted with level=3 -> next cycle level=0, out_valid=0, stamp=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the counter capture path: event record and default widths.
package counter_pkg;

  localparam int CNT_SIZE    = 4;
  localparam int CNT_STAMP_W = 8;

  typedef struct packed {
    logic [CNT_SIZE-1:0]    result;
    logic [CNT_STAMP_W-1:0] stamp;
  } cnt_event_t;

endpackage

// File: rtl/counter_event_capture_fifo.sv
// Generic synchronous FIFO; head data is read straight from storage (no fall-through),
// and the last popped word is held while empty so the output stays stable.
module event_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 12,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_last;
  logic             w_rd_en;
  logic             w_wr_en;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/counter_event_capture.sv
// Captures counter results on detect, stamps them with a free-running cycle count,
// buffers them for a valid/ready consumer, and counts events lost to a full buffer.
module counter_event_capture
  import counter_pkg::*;
#(
  parameter  int SIZE    = CNT_SIZE,
  parameter  int DEPTH   = 4,
  parameter  int STAMP_W = CNT_STAMP_W,
  parameter  int DROP_W  = 4,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               detect,
  input  logic [SIZE-1:0]    result,
  input  logic               out_ready,
  input  logic               clr_ovf,
  output logic               out_valid,
  output logic [SIZE-1:0]    out_result,
  output logic [STAMP_W-1:0] out_stamp,
  output logic [LVL_W-1:0]   level,
  output logic               ovf_flag,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int               EVT_W    = $bits(cnt_event_t);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [STAMP_W-1:0] r_stamp;
  logic               r_ovf;
  logic [DROP_W-1:0]  r_drop_cnt;
  cnt_event_t         w_push_evt;
  cnt_event_t         w_head_evt;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

  assign w_push_evt = '{result: result, stamp: r_stamp};
  assign w_pop      = out_ready & ~w_empty;
  assign w_drop     = detect & w_full & ~w_pop;

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (detect),
    .i_pop   (out_ready),
    .i_data  (w_push_evt),
    .o_data  (w_head_evt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
    end
  end

  // A drop in the same cycle as a clear leaves exactly that one drop recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_ovf) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= {{(DROP_W-1){1'b0}}, w_drop};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != DROP_MAX) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = ~w_empty;
  assign out_result = w_head_evt.result;
  assign out_stamp  = w_head_evt.stamp;
  assign ovf_flag   = r_ovf;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_counter_event_capture.sv
// Bench for counter_event_capture: fixed vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_counter_event_capture;
  import counter_pkg::*;

  localparam int SIZE    = 4;
  localparam int DEPTH   = 4;
  localparam int STAMP_W = 8;
  localparam int DROP_W  = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               detect = 1'b0;
  logic [SIZE-1:0]    result = '0;
  logic               out_ready = 1'b0;
  logic               clr_ovf = 1'b0;
  logic               out_valid;
  logic [SIZE-1:0]    out_result;
  logic [STAMP_W-1:0] out_stamp;
  logic [LVL_W-1:0]   level;
  logic               ovf_flag;
  logic [DROP_W-1:0]  drop_cnt;

  always #5 clk = ~clk;

  counter_event_capture #(
    .SIZE(SIZE), .DEPTH(DEPTH), .STAMP_W(STAMP_W), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .reset(reset), .detect(detect), .result(result),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_result(out_result), .out_stamp(out_stamp), .level(level),
    .ovf_flag(ovf_flag), .drop_cnt(drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  cnt_event_t q[$];
  cnt_event_t m_last;
  int         m_stamp;
  int         m_ovf;
  int         m_drop;

  typedef struct {
    bit rst; bit det; int res; bit rdy; bit clr;
    int ev; int eres; int estamp; int elvl; int eovf; int edrop;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit dropped;
    if (reset) begin
      q.delete();
      m_last  = '0;
      m_stamp = 0;
      m_ovf   = 0;
      m_drop  = 0;
    end else begin
      dropped = 1'b0;
      if (out_ready && q.size() > 0) m_last = q.pop_front();
      if (detect) begin
        if (q.size() < DEPTH) q.push_back('{result: result, stamp: STAMP_W'(m_stamp)});
        else dropped = 1'b1;
      end
      if (clr_ovf) begin
        m_ovf  = 0;
        m_drop = 0;
      end
      if (dropped) begin
        m_ovf = 1;
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
      m_stamp = (m_stamp + 1) % (1 << STAMP_W);
    end
  endtask

  task automatic cycle(input bit rst, input bit det, input int res, input bit rdy, input bit clr);
    cnt_event_t head;
    @(negedge clk);
    reset = rst; detect = det; result = SIZE'(res); out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_update();
    #1;
    head = (q.size() > 0) ? q[0] : m_last;
    chk("mdl_valid",  int'(out_valid),  (q.size() > 0) ? 1 : 0);
    chk("mdl_result", int'(out_result), int'(head.result));
    chk("mdl_stamp",  int'(out_stamp),  int'(head.stamp));
    chk("mdl_level",  int'(level),      q.size());
    chk("mdl_ovf",    int'(ovf_flag),   m_ovf);
    chk("mdl_drop",   int'(drop_cnt),   m_drop);
  endtask

  task automatic add(input bit rst, input bit det, input int res, input bit rdy, input bit clr,
                     input int ev, input int eres, input int estamp, input int elvl,
                     input int eovf, input int edrop);
    vec_t v;
    v.rst = rst; v.det = det; v.res = res; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.eres = eres; v.estamp = estamp; v.elvl = elvl; v.eovf = eovf; v.edrop = edrop;
    tbl.push_back(v);
  endtask

  initial begin
    // reset, idle, single capture at stamp 5 held until accepted, capture at stamp 10
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 10, 0, 0,  1, 10, 5, 1, 0, 0);
    add(0, 0, 0, 0, 0,   1, 10, 5, 1, 0, 0);
    add(0, 0, 0, 1, 0,   0, 10, 5, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 10, 5, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 10, 5, 0, 0, 0);
    add(0, 1, 3, 0, 0,   1, 3, 10, 1, 0, 0);
    add(0, 0, 0, 1, 0,   0, 3, 10, 0, 0, 0);
    // six pushes into a 4-deep buffer: two drops, then drain in order
    for (int k = 1; k <= 6; k++)
      add(0, 1, k, 0, 0,  1, 1, 12, (k < 4) ? k : 4, (k > 4) ? 1 : 0, (k > 4) ? k - 4 : 0);
    add(0, 0, 0, 1, 0,   1, 2, 13, 3, 1, 2);
    add(0, 0, 0, 1, 0,   1, 3, 14, 2, 1, 2);
    add(0, 0, 0, 1, 0,   1, 4, 15, 1, 1, 2);
    add(0, 0, 0, 1, 0,   0, 4, 15, 0, 1, 2);
    add(0, 0, 0, 0, 1,   0, 4, 15, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].det, tbl[i].res, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("v%0d_valid", i),  int'(out_valid),  tbl[i].ev);
      chk($sformatf("v%0d_result", i), int'(out_result), tbl[i].eres);
      chk($sformatf("v%0d_stamp", i),  int'(out_stamp),  tbl[i].estamp);
      chk($sformatf("v%0d_level", i),  int'(level),      tbl[i].elvl);
      chk($sformatf("v%0d_ovf", i),    int'(ovf_flag),   tbl[i].eovf);
      chk($sformatf("v%0d_drop", i),   int'(drop_cnt),   tbl[i].edrop);
    end

    // full buffer with push and pop together: no drop, new entry surfaces after 3 pops
    for (int k = 8; k <= 11; k++) cycle(0, 1, k, 0, 0);
    chk("t4_full_level", int'(level), 4);
    cycle(0, 1, 12, 1, 0);
    chk("t4_pp_level", int'(level), 4);
    chk("t4_pp_drop",  int'(drop_cnt), 0);
    chk("t4_pp_ovf",   int'(ovf_flag), 0);
    chk("t4_pp_head",  int'(out_result), 9);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
    chk("t4_new_head",  int'(out_result), 12);
    chk("t4_new_valid", int'(out_valid), 1);
    chk("t4_new_level", int'(level), 1);

    // saturation of the drop counter, clear, and clear colliding with a drop
    for (int k = 0; k < 23; k++) cycle(0, 1, k % 16, 0, 0);
    chk("t5_sat_drop", int'(drop_cnt), 15);
    chk("t5_sat_ovf",  int'(ovf_flag), 1);
    cycle(0, 0, 0, 0, 1);
    chk("t5_clr_drop", int'(drop_cnt), 0);
    chk("t5_clr_ovf",  int'(ovf_flag), 0);
    cycle(0, 1, 5, 0, 1);
    chk("t5_clrdrop_drop", int'(drop_cnt), 1);
    chk("t5_clrdrop_ovf",  int'(ovf_flag), 1);

    // reset with entries buffered discards them and restarts the stamp
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, k + 1, 0, 0);
    chk("t6_pre_level", int'(level), 3);
    cycle(1, 1, 9, 1, 1);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_drop",  int'(drop_cnt), 0);
    cycle(0, 1, 7, 0, 0);
    chk("t6_stamp0", int'(out_stamp), 0);
    chk("t6_res",    int'(out_result), 7);

    // random traffic, alternating consumer pressure so the buffer both fills and drains
    for (int n = 0; n < 800; n++) begin
      int rdy_pct;
      rdy_pct = ((n / 100) % 2 == 0) ? 25 : 75;
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 60,
            int'($urandom_range(0, 15)),
            $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
